// File: rtl/rv_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_isa_pkg
//  Brief    : RV32I opcode constants, immediate-format codes, NOP word and
//             the queued encoder entry type.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_isa_pkg;

  // Major opcodes placed in inst[6:0]
  localparam logic [6:0] EXE_R     = 7'b0110011;
  localparam logic [6:0] EXE_I     = 7'b0010011;
  localparam logic [6:0] EXE_LOAD  = 7'b0000011;
  localparam logic [6:0] EXE_S     = 7'b0100011;
  localparam logic [6:0] EXE_B     = 7'b1100011;
  localparam logic [6:0] EXE_JAL   = 7'b1101111;
  localparam logic [6:0] EXE_JALR  = 7'b1100111;
  localparam logic [6:0] EXE_AUIPC = 7'b0010111;
  localparam logic [6:0] EXE_LUI   = 7'b0110111;

  // Immediate format codes, identical to the decoder's sext_type encoding
  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_B = 3'b001,
    EXT_J = 3'b010,
    EXT_U = 3'b011,
    EXT_R = 3'b100,
    EXT_S = 3'b110
  } ext_type_e;

  // addi x0, x0, 0 - substituted for any bundle that cannot be encoded
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One queued result: error flag above the instruction word
  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_word_t;

  // True when value is the sign extension of its low 'bits' bits
  function automatic logic fits_signed(input logic [31:0] value, input int bits);
    logic [31:0] upper;
    upper = 32'($signed(value) >>> (bits - 1));
    return (upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rv_sync_fifo
//  Brief    : Single-clock FIFO, power-of-two depth, head word read directly
//             from the storage registers (no combinational path from inputs).
//  Revision : 1.0 - initial release
// ============================================================================
module rv_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   used;
  logic              do_wr;
  logic              do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (used == '0);
  assign full    = (used == (ADDR_W + 1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // Storage: cleared on reset so the head reads zero until the first write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks push minus pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   used <= used + (ADDR_W + 1)'(1);
        2'b01:   used <= used - (ADDR_W + 1)'(1);
        default: used <= used;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_inst_encoder
//  Brief    : Packs a decoded RV32I field bundle into an instruction word,
//             flags unencodable immediates/formats (queued as NOP), and
//             buffers results in a FIFO behind one encode register.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] count
);

  ext_type_e   fmt;
  logic [31:0] packed_inst;
  logic        range_err;
  enc_word_t   enc_word;

  logic        enc_valid;
  enc_word_t   enc_q;
  logic        enc_adv;
  logic        push;
  logic        pop;
  logic [CNT_W-1:0] count_q;

  logic        fifo_empty;
  logic        fifo_full;
  enc_word_t   head;

  assign fmt = ext_type_e'(in_fmt);

  // Field packing and range check for the bundle currently on the inputs
  always_comb begin
    packed_inst = 32'h0000_0000;
    range_err   = 1'b0;
    case (fmt)
      EXT_I: begin
        packed_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        range_err   = !fits_signed(in_imm, 12);
      end
      EXT_S: begin
        packed_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        range_err   = !fits_signed(in_imm, 12);
      end
      EXT_B: begin
        packed_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
        range_err   = !fits_signed(in_imm, 13) || in_imm[0];
      end
      EXT_U: begin
        packed_inst = {in_imm[31:12], in_rd, in_opcode};
        range_err   = (in_imm[11:0] != 12'h000);
      end
      EXT_J: begin
        packed_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        range_err   = !fits_signed(in_imm, 21) || in_imm[0];
      end
      EXT_R: begin
        packed_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: begin
        range_err = 1'b1;
      end
    endcase
    enc_word.err  = range_err;
    enc_word.inst = range_err ? NOP_INST : packed_inst;
  end

  // The encode slot frees when it is empty or its word moves into the FIFO.
  // count covers the encode slot as well, so accepted bundles never exceed DEPTH.
  assign enc_adv   = !enc_valid || !fifo_full;
  assign in_ready  = (count_q < CNT_W'(DEPTH)) && enc_adv;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_inst  = head.inst;
  assign out_err   = head.err;

  // Encode register: captures the packed word, holds while the FIFO is full
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid <= 1'b0;
      enc_q     <= '0;
    end else if (enc_adv) begin
      enc_valid <= push;
      if (push) begin
        enc_q <= enc_word;
      end
    end
  end

  // Occupancy of encode slot plus FIFO: accepted bundles not yet consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  rv_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enc_valid),
    .wr_data (enc_q),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_rv32i_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_inst_encoder
//  Brief    : Scoreboard bench for rv32i_inst_encoder with directed and
//             random bundles checked against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_inst_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } bundle_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [4:0]       in_rd;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] count;

  logic [32:0] sb [$];
  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 1'b0;
  bit  rand_ready = 1'b0;

  always #5 clk = ~clk;

  rv32i_inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .count     (count)
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: encoding rules written as integer ranges and shifts
  function automatic logic [32:0] model(input bundle_t b);
    longint      s;
    logic [31:0] w;
    logic        bad;
    s   = longint'($signed(b.imm));
    w   = 32'h0;
    bad = 1'b0;
    case (b.fmt)
      3'b000: begin
        bad = (s < -2048) || (s > 2047);
        w = ((b.imm & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | (32'(b.rd) << 7);
      end
      3'b110: begin
        bad = (s < -2048) || (s > 2047);
        w = (((b.imm >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
          | (32'(b.f3) << 12) | ((b.imm & 32'h1F) << 7);
      end
      3'b001: begin
        bad = (s < -4096) || (s > 4095) || (b.imm[0] == 1'b1);
        w = (((b.imm >> 12) & 32'h1) << 31) | (((b.imm >> 5) & 32'h3F) << 25)
          | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
          | (((b.imm >> 1) & 32'hF) << 8) | (((b.imm >> 11) & 32'h1) << 7);
      end
      3'b010: begin
        bad = (s < -1048576) || (s > 1048575) || (b.imm[0] == 1'b1);
        w = (((b.imm >> 20) & 32'h1) << 31) | (((b.imm >> 1) & 32'h3FF) << 21)
          | (((b.imm >> 11) & 32'h1) << 20) | (((b.imm >> 12) & 32'hFF) << 12)
          | (32'(b.rd) << 7);
      end
      3'b011: begin
        bad = (b.imm % 4096) != 0;
        w = (b.imm & 32'hFFFF_F000) | (32'(b.rd) << 7);
      end
      3'b100: begin
        w = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
          | (32'(b.f3) << 12) | (32'(b.rd) << 7);
      end
      default: bad = 1'b1;
    endcase
    w = w | 32'(b.op);
    return bad ? {1'b1, 32'h0000_0013} : {1'b0, w};
  endfunction

  function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm);
    bundle_t b;
    b.fmt = fmt; b.op = op; b.f3 = f3; b.f7 = f7;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.imm = imm;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t     b;
    logic [11:0] t12;
    logic [12:0] t13;
    logic [20:0] t21;
    int          edge_vals [11];
    edge_vals = '{2047, 2048, -2048, -2049, 4095, 4094, -4096, -4098, 1048574, 1048576, -1048576};
    b.fmt = 3'($urandom_range(0, 7));
    b.op  = 7'($urandom);
    b.f3  = 3'($urandom);
    b.f7  = 7'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.rd  = 5'($urandom);
    t12 = 12'($urandom);
    t13 = 13'($urandom);
    t21 = 21'($urandom);
    case ($urandom_range(0, 5))
      0: b.imm = $urandom;
      1: b.imm = {{20{t12[11]}}, t12};
      2: b.imm = {{19{t13[12]}}, t13[12:1], 1'b0};
      3: b.imm = {{11{t21[20]}}, t21[20:1], 1'b0};
      4: b.imm = $urandom & 32'hFFFF_F000;
      default: b.imm = 32'(edge_vals[$urandom_range(0, 10)]);
    endcase
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    in_valid  = 1'b1;
    in_fmt    = b.fmt;
    in_opcode = b.op;
    in_funct3 = b.f3;
    in_funct7 = b.f7;
    in_rs1    = b.rs1;
    in_rs2    = b.rs2;
    in_rd     = b.rd;
    in_imm    = b.imm;
  endtask

  // Waits for the current bundle to be taken; records its expected result
  task automatic wait_accept(input logic [32:0] exp);
    bit done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 64 cycles");
    end
  endtask

  task automatic send(input bundle_t b, input logic [32:0] exp);
    @(posedge clk);
    #1;
    drive(b);
    wait_accept(exp);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      $display("FAIL drain_timeout: %0d entries outstanding, expected 0", sb.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: occupancy equals accepted-minus-consumed; each consumed head
  // must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [32:0] exp;
    int          exp_cnt;
    #2;
    if (mon_en && !rst) begin
      exp_cnt = sb.size() - ((in_valid && in_ready) ? 1 : 0);
      chk("count", {30'b0, count}, 33'(exp_cnt));
      chk("in_ready", {32'b0, in_ready}, {32'b0, (exp_cnt < DEPTH)});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", {out_err, out_inst});
        end else begin
          exp = sb.pop_front();
          chk("head", {out_err, out_inst}, exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bundle_t b;
    rst = 1'b1;
    in_valid = 1'b0; in_fmt = 3'b0; in_opcode = 7'b0; in_funct3 = 3'b0; in_funct7 = 7'b0;
    in_rs1 = 5'b0; in_rs2 = 5'b0; in_rd = 5'b0; in_imm = 32'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {32'b0, out_valid}, 33'h0);
    chk("reset_out_inst",  {1'b0, out_inst},   33'h0);
    chk("reset_out_err",   {32'b0, out_err},   33'h0);
    chk("reset_in_ready",  {32'b0, in_ready},  33'h1);
    chk("reset_count",     {30'b0, count},     33'h0);
    mon_en = 1'b1;

    // Directed encodings with known words
    @(posedge clk); #1 out_ready = 1'b1;
    send(mk(3'b000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5),           {1'b0, 32'h0050_0093});
    send(mk(3'b110, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8),           {1'b0, 32'h0020_A423});
    send(mk(3'b001, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC),   {1'b0, 32'hFE20_8EE3});
    send(mk(3'b010, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8),           {1'b0, 32'h0080_00EF});
    send(mk(3'b011, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000),   {1'b0, 32'h1234_52B7});
    send(mk(3'b001, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3),           {1'b1, 32'h0000_0013});
    send(mk(3'b000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048),        {1'b1, 32'h0000_0013});
    send(mk(3'b000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5),           {1'b0, 32'h0050_0093});
    send(mk(3'b101, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0),           {1'b1, 32'h0000_0013});
    idle();
    drain();

    // Fill to DEPTH with the consumer stalled, then release it
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = rand_bundle();
      send(b, model(b));
    end
    b = rand_bundle();
    @(posedge clk); #1 drive(b);
    @(negedge clk);
    chk("full_in_ready", {32'b0, in_ready}, 33'h0);
    chk("full_count",    {30'b0, count},    33'd4);
    repeat (2) @(negedge clk);
    chk("full_held", {32'b0, in_ready}, 33'h0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept(model(b));
    for (int i = 0; i < 4; i++) begin
      b = rand_bundle();
      send(b, model(b));
    end
    idle();
    drain();

    // Reset with entries queued, then check the single-cycle encode latency
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = rand_bundle();
      send(b, model(b));
    end
    idle();
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count",     {30'b0, count},     33'h0);
    chk("rst_out_valid", {32'b0, out_valid}, 33'h0);
    b = mk(3'b000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    send(b, {1'b0, 32'h0050_0093});
    idle();
    @(negedge clk);
    chk("lat_not_yet", {32'b0, out_valid}, 33'h0);
    @(negedge clk);
    chk("lat_head_valid", {32'b0, out_valid}, 33'h1);
    chk("lat_head_word",  {out_err, out_inst}, {1'b0, 32'h0050_0093});
    drain();

    // Random bundles with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b = rand_bundle();
      send(b, model(b));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    @(negedge clk);
    chk("final_count", {30'b0, count}, 33'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
